// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: state encoding and memory opcodes for the data-memory access stage.
package mem_stage_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: execute-side, memory-side and writeback signals of the access stage.
interface mem_access_stage_if #(parameter int DATA_W = 16, parameter int ADDR_W = 16);
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_op;
  logic [DATA_W-1:0] ex_alu_out;
  logic [DATA_W-1:0] ex_wdata;
  logic [3:0]        ex_rd;
  logic              ex_wen;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic              wb_wen;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;
  modport master (
    input  ex_valid, ex_op, ex_alu_out, ex_wdata, ex_rd, ex_wen, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_wen, wb_rd, wb_data, wb_err
  );
  modport slave (
    output ex_valid, ex_op, ex_alu_out, ex_wdata, ex_rd, ex_wen, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_wen, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts ACCESS cycles without ack; expire flags the TIMEOUT-th such cycle.
module mem_timeout_ctr #(parameter int TIMEOUT = 15) (
  input  logic clk,
  input  logic rst,
  input  logic count,
  input  logic clear,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : count ? cnt_q + 1'b1 : cnt_q;
  assign expire = count && cnt_q == W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: LW/SW req/ack access to data memory plus one writeback record per instruction.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT cycles without mem_ack.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  mem_access_stage_if.master bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [3:0]        wb_rd_q, wb_rd_d;
  logic              we_q, we_d, wb_wen_q, wb_wen_d, wb_err_q, wb_err_d;
  logic              in_access, take, expire;
  assign in_access = state_q == S_ACCESS;
  assign take      = bus.ex_valid && !in_access;
`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk, .rst, .count(in_access && !bus.mem_ack), .clear(!in_access), .expire
  );
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wb_wen_d  = wb_wen_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
    if (in_access) begin
      // an ack on the expiring cycle still completes normally
      if (bus.mem_ack || expire) begin
        state_d   = S_RESP;
        wb_err_d  = !bus.mem_ack;
        wb_wen_d  = bus.mem_ack && !we_q;
        wb_data_d = (bus.mem_ack && !we_q) ? bus.mem_rdata : '0;
      end
    end else if (take) begin
      wb_rd_d   = bus.ex_rd;
      wb_err_d  = 1'b0;
      wb_wen_d  = 1'b0;
      wb_data_d = '0;
      if (!is_mem_op(bus.ex_op)) begin
        state_d   = S_RESP;
        wb_wen_d  = bus.ex_wen;
        wb_data_d = bus.ex_alu_out;
      end else if (bus.ex_alu_out[0]) begin
        state_d  = S_RESP;
        wb_err_d = 1'b1;
      end else begin
        state_d = S_ACCESS;
        addr_d  = bus.ex_alu_out[ADDR_W-1:0];
        we_d    = bus.ex_op == OP_SW;
        wdata_d = bus.ex_wdata;
      end
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wb_wen_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wb_wen_q  <= wb_wen_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
    end
  assign bus.ex_ready  = !in_access;
  assign bus.mem_req   = in_access;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.wb_valid  = state_q == S_RESP;
  assign bus.wb_wen    = wb_wen_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized instructions checked against per-instruction expected records.
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_access_stage_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  mem_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // one instruction; lat = cycle of ACCESS on which mem_ack is given (>=1)
  task automatic do_instr(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] wd,
                          input logic [3:0] rd, input logic wen, input int lat);
    logic        is_mem, exp_wen, exp_err;
    logic [15:0] exp_data, rdata;
    is_mem = (op == 4'b1000) || (op == 4'b1001);
    @(negedge clk);
    chk("ready_idle", bus.ex_ready, 1'b1);
    bus.ex_valid = 1'b1; bus.ex_op = op; bus.ex_alu_out = alu; bus.ex_wdata = wd;
    bus.ex_rd = rd; bus.ex_wen = wen;
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 1'b0; bus.mem_ack = 1'b0;
    bus.ex_op = 4'($urandom); bus.ex_alu_out = 16'($urandom);
    exp_err = 1'b0; exp_wen = wen; exp_data = alu;
    if (is_mem && alu[0]) begin
      exp_err = 1'b1; exp_wen = 1'b0;
    end else if (is_mem) begin
      rdata = 16'h0;
      for (int i = 1; i <= lat; i++) begin
        chk("mem_req", bus.mem_req, 1'b1);
        chk("ready_busy", bus.ex_ready, 1'b0);
        chk("no_wb_busy", bus.wb_valid, 1'b0);
        chk("mem_addr", bus.mem_addr, alu);
        chk("mem_we", bus.mem_we, op == 4'b1001);
        if (op == 4'b1001) chk("mem_wdata", bus.mem_wdata, wd);
        rdata = 16'($urandom);
        bus.mem_rdata = rdata;
        bus.mem_ack = (i == lat);
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'($urandom);
      end
      exp_wen = (op == 4'b1000);
      exp_data = (op == 4'b1000) ? rdata : 16'h0;
    end
    chk("wb_valid", bus.wb_valid, 1'b1);
    chk("wb_err", bus.wb_err, exp_err);
    chk("wb_wen", bus.wb_wen, exp_wen);
    chk("wb_rd", bus.wb_rd, rd);
    if (!exp_err) chk("wb_data", bus.wb_data, exp_data);
    chk("req_resp", bus.mem_req, 1'b0);
  endtask
  initial begin
    logic [3:0]  op;
    logic [15:0] alu, prev_alu;
    logic [3:0]  prev_rd;
    logic        prev_wen;
    bus.ex_valid = 1'b0; bus.ex_op = 4'h0; bus.ex_alu_out = 16'h0; bus.ex_wdata = 16'h0;
    bus.ex_rd = 4'h0; bus.ex_wen = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    #12;
    chk("rst_ready", bus.ex_ready, 1'b1);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_wb_data", bus.wb_data, 16'h0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    do_instr(4'b0000, 16'h1234, 16'h0, 4'd3, 1'b1, 1);
    do_instr(4'b1000, 16'h0040, 16'h0, 4'd5, 1'b1, 3);
    do_instr(4'b1001, 16'h0010, 16'hA5A5, 4'd2, 1'b1, 1);
    do_instr(4'b1000, 16'h0041, 16'h0, 4'd7, 1'b1, 1);
    do_instr(4'b1000, 16'h00F0, 16'h0, 4'd9, 1'b1, 15);
    for (int n = 0; n < 40; n++) begin
      case ($urandom % 4)
        0, 1:    op = 4'($urandom % 8);
        2:       op = 4'b1000;
        default: op = 4'b1001;
      endcase
      alu = 16'($urandom);
      if ($urandom % 4 != 0) alu[0] = 1'b0;
      do_instr(op, alu, 16'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(1, 5)));
    end
    // back-to-back non-memory ops, one record per cycle
    prev_alu = 16'h0; prev_rd = 4'h0; prev_wen = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("b2b_valid", bus.wb_valid, 1'b1);
        chk("b2b_data", bus.wb_data, prev_alu);
        chk("b2b_rd", bus.wb_rd, prev_rd);
        chk("b2b_wen", bus.wb_wen, prev_wen);
        chk("b2b_ready", bus.ex_ready, 1'b1);
      end
      bus.ex_valid = (k < 8);
      prev_alu = 16'($urandom); prev_rd = 4'($urandom); prev_wen = 1'($urandom);
      bus.ex_op = 4'($urandom % 8); bus.ex_alu_out = prev_alu;
      bus.ex_rd = prev_rd; bus.ex_wen = prev_wen;
    end
    @(negedge clk);
    chk("b2b_idle", bus.wb_valid, 1'b0);
    // reset in the middle of an access, then a late ack
    bus.ex_valid = 1'b1; bus.ex_op = 4'b1000; bus.ex_alu_out = 16'h0080;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    chk("pre_rst_req", bus.mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_drop_req", bus.mem_req, 1'b0);
    chk("rst_drop_ready", bus.ex_ready, 1'b1);
    chk("rst_drop_wb", bus.wb_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("late_ack_wb", bus.wb_valid, 1'b0);
    chk("late_ack_req", bus.mem_req, 1'b0);
    @(negedge clk);
    chk("late_ack_wb2", bus.wb_valid, 1'b0);
    // access with no ack
    bus.ex_valid = 1'b1; bus.ex_op = 4'b1000; bus.ex_alu_out = 16'h0100; bus.ex_rd = 4'd4;
    @(negedge clk);
    bus.ex_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      chk("to_req", bus.mem_req, 1'b1);
      @(negedge clk);
    end
    chk("to_req_drop", bus.mem_req, 1'b0);
    chk("to_wb_valid", bus.wb_valid, 1'b1);
    chk("to_wb_err", bus.wb_err, 1'b1);
    chk("to_wb_wen", bus.wb_wen, 1'b0);
`else
    for (int i = 0; i < 40; i++) begin
      chk("wait_req", bus.mem_req, 1'b1);
      @(negedge clk);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("wait_wb_valid", bus.wb_valid, 1'b1);
    chk("wait_wb_err", bus.wb_err, 1'b0);
    chk("wait_wb_data", bus.wb_data, 16'h5A5A);
`endif
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
